// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types and constants used by the fetch stage.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/response bus (req/gnt, in-order rvalid).
interface ifetch_if;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush beats push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  fetch_entry_t             data_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t        mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         count_q;
  logic                do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// RV32I fetch stage: PC, request credit, stale-response dropping and the
// fetch buffer feeding decode.
module ifetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_F,
  input  logic        i_pc_src_EX,
  input  logic [31:0] i_pc_target_EX,
  ifetch_if.master    imem,
  output logic        o_valid_F,
  output logic [31:0] o_instr_F,
  output logic [31:0] o_pc_F,
  output logic [31:0] o_pc_plus4_F
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_q, drop_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  fifo_in;
  logic          pop;
  logic          push;
  logic          req;
  logic          fire;
  logic [31:0]   in_flight;
  logic [31:0]   redirect_pc;

  always_comb begin
    pop         = !fifo_empty && !i_stall_F;
    redirect_pc = i_pc_target_EX & ~32'h3;
    // Credit counts buffered plus outstanding words so a response always has a slot.
    in_flight   = 32'(fifo_count) + 32'(outstanding_q) - 32'(pop);
    req         = !i_rst && !i_pc_src_EX
                  && (32'(outstanding_q) < MAX_OUTSTANDING)
                  && (in_flight < FIFO_DEPTH);
    fire        = req && imem.gnt;

    outstanding_d = outstanding_q + OW'(fire) - OW'(imem.rvalid);
    push          = imem.rvalid && (drop_q == '0) && !i_pc_src_EX;
    fifo_in.pc    = resp_pc_q;
    fifo_in.instr = imem.rdata;

    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    drop_d    = drop_q;
    if (i_pc_src_EX) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      drop_d    = outstanding_d;
    end else begin
      if (fire) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem.rvalid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else begin
          resp_pc_d = resp_pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_pc_src_EX),
    .data_i  (fifo_in),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign imem.req     = req;
  assign imem.addr    = pc_q;
  assign o_valid_F    = !fifo_empty;
  assign o_instr_F    = o_valid_F ? fifo_head.instr : NOP_INSTR;
  assign o_pc_F       = o_valid_F ? fifo_head.pc : 32'h0;
  assign o_pc_plus4_F = o_valid_F ? fifo_head.pc + 32'd4 : 32'h0;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a latency-configurable memory returns data = address.
module tb_ifetch;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_F = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] target = 32'h0;
  logic        valid_F;
  logic [31:0] instr_F, pc_F, pc4_F;

  ifetch_if bus ();

  ifetch #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall_F      (stall_F),
    .i_pc_src_EX    (pc_src),
    .i_pc_target_EX (target),
    .imem           (bus.master),
    .o_valid_F      (valid_F),
    .o_instr_F      (instr_F),
    .o_pc_F         (pc_F),
    .o_pc_plus4_F   (pc4_F)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // memory model and scoreboard state
  logic [31:0] mem_addr[$];
  int          mem_rdy[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  int          outst = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gmode = 0;       // 0 always grant, 1 every other cycle, 2 never
  bit          arm_on_redir = 1'b0;
  int          arm_cyc = 0;
  int          arm_lat = 0;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_tgt = 32'h0;
  bit          prev_hold = 1'b0;
  logic [31:0] held_pc = 32'h0;

  task automatic step(input logic stall, input logic redir, input logic [31:0] tgt);
    logic        rsp;
    logic        fire;
    logic [31:0] e;
    stall_F = stall;
    pc_src  = redir;
    target  = tgt;
    bus.gnt = (gmode == 0) ? 1'b1 : (gmode == 1) ? (cyc % 2 == 0) : 1'b0;
    rsp = (mem_addr.size() > 0) && (mem_rdy[0] <= cyc);
    bus.rvalid = rsp;
    bus.rdata  = rsp ? mem_addr[0] : 32'h0;
    #1;
    if (bus.req) check("fetch_addr", bus.addr, exp_pc);
    check("credit_limit", {31'b0, bus.req && (outst >= MAXO)}, 32'h0);
    if (redir) check("req_in_redirect", {31'b0, bus.req}, 32'h0);
    if (prev_redir) begin
      check("valid_after_redirect", {31'b0, valid_F}, 32'h0);
      if (arm_lat != 0) begin
        check("redir_req", {31'b0, bus.req}, 32'h1);
        check("redir_addr", bus.addr, prev_tgt & ~32'h3);
      end
    end
    if (prev_hold) begin
      check("stall_hold_valid", {31'b0, valid_F}, 32'h1);
      check("stall_hold_pc", pc_F, held_pc);
    end
    if (arm_lat != 0 && valid_F) begin
      check("first_valid_lat", 32'(cyc - arm_cyc), 32'(arm_lat));
      arm_lat = 0;
    end
    if (!valid_F) begin
      check("idle_instr", instr_F, 32'h0000_0013);
      check("idle_pc", pc_F | pc4_F, 32'h0);
    end else if (!redir) begin
      check("sb_nonempty", {31'b0, exp_q.size() > 0}, 32'h1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("out_pc", pc_F, e);
        check("out_instr", instr_F, e);
        check("out_pc4", pc4_F, e + 32'd4);
        if (!stall) void'(exp_q.pop_front());
      end
    end
    fire       = bus.req && bus.gnt;
    prev_hold  = stall && valid_F && !redir;
    held_pc    = pc_F;
    prev_redir = redir;
    prev_tgt   = tgt;
    @(posedge clk);
    if (fire) begin
      mem_addr.push_back(exp_pc);
      mem_rdy.push_back(cyc + lat);
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
      outst++;
    end
    if (rsp) begin
      void'(mem_addr.pop_front());
      void'(mem_rdy.pop_front());
      outst--;
    end
    if (redir) begin
      exp_q.delete();
      exp_pc = tgt & ~32'h3;
      if (arm_on_redir) begin
        arm_cyc = cyc;
        arm_lat = 3;
      end else begin
        arm_lat = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bus.gnt    = 1'b1;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'b0, bus.req}, 32'h0);
    check("rst_valid", {31'b0, valid_F}, 32'h0);
    check("rst_instr", instr_F, 32'h0000_0013);
    check("rst_pc", pc_F, 32'h0);
    check("rst_pc4", pc4_F, 32'h0);
    rst = 1'b0;
    arm_cyc = 0;
    arm_lat = 2;

    // streaming until pc 8 reaches the output, then stall there
    for (int i = 0; i < 20; i++) begin
      if (valid_F && pc_F == 32'h8) break;
      step(1'b0, 1'b0, 32'h0);
    end
    check("stall_at_pc8", pc_F, 32'h8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
    check("stall_credit_exhausted", {31'b0, bus.req}, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);

    // redirect with two requests in flight on slow memory
    lat = 3;
    for (int i = 0; i < 10; i++) begin
      if (outst == 2) break;
      step(1'b0, 1'b0, 32'h0);
    end
    check("two_outstanding", 32'(outst), 32'd2);
    step(1'b0, 1'b1, 32'h0000_0100);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // misaligned redirect target on 1-cycle memory
    arm_on_redir = 1'b1;
    step(1'b0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

    // 3-cycle memory with alternating grant
    arm_on_redir = 1'b0;
    lat = 3;
    gmode = 1;
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 32'h0);
    lat = 1;
    gmode = 0;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);

    // redirect coinciding with a response and a stall
    arm_on_redir = 1'b1;
    check("pre_collide_rsp", {31'b0, (mem_addr.size() > 0) && (mem_rdy[0] <= cyc)}, 32'h1);
    check("pre_collide_valid", {31'b0, valid_F}, 32'h1);
    step(1'b1, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

    // drain: stop granting, everything buffered must come out
    arm_on_redir = 1'b0;
    gmode = 2;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", {31'b0, valid_F}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
